// File: rtl/watch_mode_ctrl.sv
// Top-level mode sequencer for the multi-purpose watch: owns the current mode,
// routes function keys to the active block, handles alarm preemption and idle return.
module watch_mode_ctrl #(
    parameter int unsigned IDLE_SEC = 30,
    parameter int unsigned CNT_W    = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  btn_pedge,
    input  logic        sec_tick,
    input  logic [15:0] clock_value,
    input  logic [15:0] swatch_value,
    input  logic [15:0] timer_value,
    input  logic        swatch_run,
    input  logic        timer_run,
    input  logic        alarm_req,
    output logic [2:0]  btn_clock,
    output logic [2:0]  btn_swatch,
    output logic [2:0]  btn_timer,
    output logic        alarm_clr,
    output logic [1:0]  mode,
    output logic [3:0]  led_mode,
    output logic [15:0] value,
    output logic        blink
);

    typedef enum logic [1:0] {
        S_CLOCK  = 2'd0,
        S_SWATCH = 2'd1,
        S_TIMER  = 2'd2,
        S_ALARM  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_SEC);

    state_t           state, state_nxt, saved_mode, saved_nxt, norm_nxt;
    logic [CNT_W-1:0] idle_cnt, idle_nxt;
    logic [2:0]       btn_clock_nxt, btn_swatch_nxt, btn_timer_nxt;
    logic             alarm_clr_nxt, blink_nxt;
    logic             any_btn, idle_full, run_flag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_CLOCK;
            saved_mode <= S_CLOCK;
            idle_cnt   <= '0;
            btn_clock  <= '0;
            btn_swatch <= '0;
            btn_timer  <= '0;
            alarm_clr  <= 1'b0;
            blink      <= 1'b0;
        end else begin
            state      <= state_nxt;
            saved_mode <= saved_nxt;
            idle_cnt   <= idle_nxt;
            btn_clock  <= btn_clock_nxt;
            btn_swatch <= btn_swatch_nxt;
            btn_timer  <= btn_timer_nxt;
            alarm_clr  <= alarm_clr_nxt;
            blink      <= blink_nxt;
        end
    end

    always_comb begin
        any_btn   = |btn_pedge;
        idle_full = (idle_cnt == IDLE_MAX);
        run_flag  = (state == S_SWATCH) ? swatch_run : timer_run;

        // Where the non-alarm sequencing would go; also what an alarm parks in saved_mode.
        norm_nxt = state;
        if (btn_pedge[3]) begin
            case (state)
                S_CLOCK:  norm_nxt = S_SWATCH;
                S_SWATCH: norm_nxt = S_TIMER;
                default:  norm_nxt = S_CLOCK;
            endcase
        end else if ((state == S_SWATCH || state == S_TIMER) && idle_full && !run_flag) begin
            norm_nxt = S_CLOCK;
        end

        state_nxt      = state;
        saved_nxt      = saved_mode;
        btn_clock_nxt  = '0;
        btn_swatch_nxt = '0;
        btn_timer_nxt  = '0;
        alarm_clr_nxt  = 1'b0;

        if (state == S_ALARM) begin
            if (any_btn) begin
                state_nxt     = saved_mode;
                alarm_clr_nxt = 1'b1;
            end
        end else if (alarm_req) begin
            state_nxt = S_ALARM;
            saved_nxt = norm_nxt;
        end else begin
            state_nxt = norm_nxt;
            case (state)
                S_CLOCK:  btn_clock_nxt  = btn_pedge[2:0];
                S_SWATCH: btn_swatch_nxt = btn_pedge[2:0];
                S_TIMER:  btn_timer_nxt  = btn_pedge[2:0];
                default:  ;
            endcase
        end

        if (state_nxt != S_ALARM) begin
            blink_nxt = 1'b0;
        end else if (state != S_ALARM) begin
            blink_nxt = 1'b1;
        end else begin
            blink_nxt = blink ^ sec_tick;
        end

        if (any_btn || state_nxt != state || state == S_CLOCK || state == S_ALARM) begin
            idle_nxt = '0;
        end else if (sec_tick && !idle_full) begin
            idle_nxt = idle_cnt + CNT_W'(1);
        end else begin
            idle_nxt = idle_cnt;
        end
    end

    always_comb begin
        mode     = state;
        led_mode = 4'b0001 << state;
        case (state)
            S_CLOCK:  value = clock_value;
            S_SWATCH: value = swatch_value;
            default:  value = timer_value;
        endcase
    end

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Self-checking bench for watch_mode_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_watch_mode_ctrl;

    localparam int IDLE = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  btn_pedge = '0;
    logic        sec_tick = 1'b0;
    logic [15:0] clock_value = 16'h1200;
    logic [15:0] swatch_value = 16'h1234;
    logic [15:0] timer_value = 16'h0500;
    logic        swatch_run = 1'b0;
    logic        timer_run = 1'b0;
    logic        alarm_req = 1'b0;
    logic [2:0]  btn_clock, btn_swatch, btn_timer;
    logic        alarm_clr;
    logic [1:0]  mode;
    logic [3:0]  led_mode;
    logic [15:0] value;
    logic        blink;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    watch_mode_ctrl #(.IDLE_SEC(IDLE), .CNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .btn_pedge(btn_pedge), .sec_tick(sec_tick),
        .clock_value(clock_value), .swatch_value(swatch_value), .timer_value(timer_value),
        .swatch_run(swatch_run), .timer_run(timer_run), .alarm_req(alarm_req),
        .btn_clock(btn_clock), .btn_swatch(btn_swatch), .btn_timer(btn_timer),
        .alarm_clr(alarm_clr), .mode(mode), .led_mode(led_mode), .value(value), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0..3 = clock, stopwatch, timer, alarm.
    int       m_mode = 0, m_saved = 0, m_idle = 0;
    bit       m_blink = 0, m_clr = 0;
    bit [2:0] m_btn0 = 0, m_btn1 = 0, m_btn2 = 0;

    always @(posedge clk or negedge reset_n) begin
        int nxt;
        bit any;
        bit run;
        if (!reset_n) begin
            m_mode = 0; m_saved = 0; m_idle = 0; m_blink = 0; m_clr = 0;
            m_btn0 = 0; m_btn1 = 0; m_btn2 = 0;
        end else begin
            any = (btn_pedge != 4'd0);
            run = (m_mode == 1) ? swatch_run : timer_run;
            m_btn0 = 0; m_btn1 = 0; m_btn2 = 0; m_clr = 0;
            if (m_mode == 3) begin
                nxt = any ? m_saved : 3;
                m_clr = any;
            end else begin
                nxt = m_mode;
                if (btn_pedge[3]) nxt = (m_mode + 1) % 3;
                else if (m_mode != 0 && m_idle == IDLE && !run) nxt = 0;
                if (alarm_req) begin
                    m_saved = nxt;
                    nxt = 3;
                end else if (m_mode == 0) m_btn0 = btn_pedge[2:0];
                else if (m_mode == 1) m_btn1 = btn_pedge[2:0];
                else m_btn2 = btn_pedge[2:0];
            end
            if (nxt != 3) m_blink = 0;
            else if (m_mode != 3) m_blink = 1;
            else m_blink = m_blink ^ sec_tick;
            if (any || nxt != m_mode || m_mode == 0 || m_mode == 3) m_idle = 0;
            else if (sec_tick && m_idle < IDLE) m_idle = m_idle + 1;
            m_mode = nxt;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mode", 32'(mode), 32'(m_mode));
            chk("led_mode", 32'(led_mode), 32'(1 << m_mode));
            chk("value", 32'(value),
                32'((m_mode == 0) ? clock_value : (m_mode == 1) ? swatch_value : timer_value));
            chk("blink", 32'(blink), 32'(m_blink));
            chk("alarm_clr", 32'(alarm_clr), 32'(m_clr));
            chk("btn_clock", 32'(btn_clock), 32'(m_btn0));
            chk("btn_swatch", 32'(btn_swatch), 32'(m_btn1));
            chk("btn_timer", 32'(btn_timer), 32'(m_btn2));
        end
    end

    // Present inputs for one clock edge, then return just after it with pulses cleared.
    task automatic cyc(input logic [3:0] bp, input logic tk);
        btn_pedge = bp;
        sec_tick  = tk;
        @(posedge clk);
        #1;
        btn_pedge = '0;
        sec_tick  = 1'b0;
    endtask

    task automatic chk_btns_zero(input string name);
        chk({name, "_btns"}, 32'({btn_clock, btn_swatch, btn_timer}), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk_en  = 1'b1;
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_led", 32'(led_mode), 32'b0001);
        chk("rst_blink", 32'(blink), 32'd0);
        chk("rst_clr", 32'(alarm_clr), 32'd0);
        chk_btns_zero("rst");

        cyc(4'b1000, 1'b0);
        chk("mk1_mode", 32'(mode), 32'd1);
        chk("mk1_led", 32'(led_mode), 32'b0010);
        chk_btns_zero("mk1");
        cyc(4'b1000, 1'b0);
        chk("mk2_mode", 32'(mode), 32'd2);
        chk("mk2_led", 32'(led_mode), 32'b0100);
        chk_btns_zero("mk2");
        cyc(4'b1000, 1'b0);
        chk("mk3_mode", 32'(mode), 32'd0);
        chk("mk3_led", 32'(led_mode), 32'b0001);
        chk_btns_zero("mk3");

        cyc(4'b1000, 1'b0);
        cyc(4'b0001, 1'b0);
        chk("route_sw", 32'(btn_swatch), 32'b001);
        chk("route_clk", 32'(btn_clock), 32'd0);
        chk("route_tmr", 32'(btn_timer), 32'd0);
        chk("route_val", 32'(value), 32'h1234);
        cyc(4'b0000, 1'b0);
        chk("route_end", 32'(btn_swatch), 32'd0);

        alarm_req = 1'b1;
        cyc(4'b1000, 1'b0);
        chk("alm_mode", 32'(mode), 32'd3);
        chk("alm_val", 32'(value), 32'h0500);
        chk("alm_blink", 32'(blink), 32'd1);
        cyc(4'b0010, 1'b0);
        alarm_req = 1'b0;
        chk("alm_clr", 32'(alarm_clr), 32'd1);
        chk("alm_ret", 32'(mode), 32'd2);
        chk("alm_btn_tmr", 32'(btn_timer), 32'd0);
        chk("alm_blink_off", 32'(blink), 32'd0);
        cyc(4'b0000, 1'b0);
        chk("alm_clr_1cyc", 32'(alarm_clr), 32'd0);
        chk("alm_stay", 32'(mode), 32'd2);

        for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b1);
        chk("idle_hold", 32'(mode), 32'd2);
        cyc(4'b0000, 1'b0);
        chk("idle_ret", 32'(mode), 32'd0);

        cyc(4'b1000, 1'b0);
        cyc(4'b1000, 1'b0);
        cyc(4'b0000, 1'b1);
        cyc(4'b0100, 1'b1);
        chk("idle_btn_route", 32'(btn_timer), 32'b100);
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b0);
        chk("idle_clr_wins", 32'(mode), 32'd2);
        cyc(4'b0000, 1'b1);
        chk("idle_3rd", 32'(mode), 32'd2);
        cyc(4'b0000, 1'b0);
        chk("idle_ret2", 32'(mode), 32'd0);

        cyc(4'b1000, 1'b0);
        swatch_run = 1'b1;
        for (int i = 0; i < 10; i++) cyc(4'b0000, 1'b1);
        chk("run_hold", 32'(mode), 32'd1);
        swatch_run = 1'b0;
        cyc(4'b0000, 1'b0);
        chk("run_ret", 32'(mode), 32'd0);

        alarm_req = 1'b1;
        cyc(4'b0000, 1'b0);
        chk("ra_mode", 32'(mode), 32'd3);
        cyc(4'b0000, 1'b1);
        chk("ra_tog0", 32'(blink), 32'd0);
        cyc(4'b0000, 1'b1);
        chk("ra_tog1", 32'(blink), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ra_mode_rst", 32'(mode), 32'd0);
        chk("ra_blink_rst", 32'(blink), 32'd0);
        chk("ra_clr_rst", 32'(alarm_clr), 32'd0);
        chk("ra_led_rst", 32'(led_mode), 32'b0001);
        alarm_req = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            btn_pedge    = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
            sec_tick     = ($urandom_range(0, 2) == 0);
            alarm_req    = ($urandom_range(0, 40) == 0) ? 1'b1 : (alarm_req && $urandom_range(0, 3) != 0);
            swatch_run   = ($urandom_range(0, 30) == 0) ? ~swatch_run : swatch_run;
            timer_run    = ($urandom_range(0, 30) == 0) ? ~timer_run : timer_run;
            clock_value  = 16'($urandom);
            swatch_value = 16'($urandom);
            timer_value  = 16'($urandom);
            reset_n      = ($urandom_range(0, 500) != 0);
            @(posedge clk);
            #1;
        end
        btn_pedge = '0;
        sec_tick  = 1'b0;
        reset_n   = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
